// File: rtl/pp_stream_rr_arbiter.sv
// pp_stream_rr_arbiter
//
// Merges NUM_REQ upstream stream FIFOs into one downstream FIFO write port.
// The port is granted to one requester at a time for a burst of up to
// BURST_LEN beats. Grants rotate round-robin, starting from the requester
// after the previous holder. Every beat carries the index of its source on
// out_src.
//
// Handshake: an upstream word is valid whenever req_empty_n[i]=1. It is
// consumed at the clock edge where req_read[i]=1. A downstream word is
// accepted at the clock edge where out_write=1, and out_write is only raised
// while out_full_n=1. Both strobes are asserted in the same cycle for the
// same word. The data path is purely combinational (dout -> din), so no word
// is ever held inside this block.
//
// Each grant costs one IDLE cycle for the round-robin pick. A turn ends when
// enable drops, when the holder runs empty, or on its BURST_LEN-th beat.
// The last of these cases transfers its final beat in the ending cycle.
// Reset is synchronous. It also masks the strobes in the cycle where it is
// asserted, so an in-flight burst stops without popping another word.

module pp_stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WIDTH  = 2,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_empty_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dout,
  output logic [NUM_REQ-1:0]            req_read,
  input  logic                          out_full_n,
  output logic                          out_write,
  output logic [DATA_WIDTH-1:0]         out_din,
  output logic [SRC_WIDTH-1:0]          out_src,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          beat_total
);

  // Beat counter only has to reach BURST_LEN-1 before the turn ends.
  localparam int                   BCW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0]       LAST_BEAT = BCW'(BURST_LEN - 1);
  localparam logic [SRC_WIDTH-1:0] LAST_REQ  = SRC_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SRC_WIDTH-1:0]   grant_idx_q, grant_idx_d;
  logic [SRC_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]   beat_total_q, beat_total_d;

  logic                   sel_empty_n;
  logic [DATA_WIDTH-1:0]  sel_dout;
  logic                   pick_valid;
  logic [SRC_WIDTH-1:0]   pick_idx;
  logic                   xfer;
  logic                   turn_end;
  logic [SRC_WIDTH-1:0]   next_ptr;

  // First set bit of vec at or after ptr, wrapping at NUM_REQ-1.
  // Returns {found, index}. Written with a bounded loop so that a NUM_REQ
  // that is not a power of two wraps correctly.
  function automatic logic [SRC_WIDTH:0] rr_pick(
    input logic [NUM_REQ-1:0]   vec,
    input logic [SRC_WIDTH-1:0] ptr
  );
    logic                 found;
    logic [SRC_WIDTH-1:0] idx;
    int                   j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && vec[j]) begin
        found = 1'b1;
        idx   = SRC_WIDTH'(j);
      end
    end
    return {found, idx};
  endfunction

  // Select the granted requester's data-available flag and word.
  always_comb begin
    sel_empty_n = 1'b0;
    sel_dout    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == SRC_WIDTH'(i)) begin
        sel_empty_n = req_empty_n[i];
        sel_dout    = req_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin candidate for the next grant, searched from rr_ptr.
  always_comb begin
    {pick_valid, pick_idx} = rr_pick(req_empty_n, rr_ptr_q);
  end

  // Beat qualification and end-of-turn detection for the current holder.
  always_comb begin
    xfer     = (state_q == ST_ACTIVE) && !reset && enable && sel_empty_n && out_full_n;
    turn_end = !enable || !sel_empty_n || (xfer && (beat_cnt_q == LAST_BEAT));
    next_ptr = (grant_idx_q == LAST_REQ) ? '0 : grant_idx_q + SRC_WIDTH'(1);
  end

  // Strobes and tagged data toward the FIFOs: pop only the holder, push in step.
  always_comb begin
    req_read = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_read[i] = xfer && (grant_idx_q == SRC_WIDTH'(i));
    end
    out_write  = xfer;
    out_din    = sel_dout;
    out_src    = grant_idx_q;
    busy       = (state_q == ST_ACTIVE);
    beat_total = beat_total_q;
  end

  // Next-state logic: IDLE picks a holder, ACTIVE counts beats until the turn ends.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    beat_total_d = beat_total_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_valid) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
          state_d     = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          beat_cnt_d   = beat_cnt_q + BCW'(1);
          beat_total_d = beat_total_q + CNT_WIDTH'(1);
        end
        if (turn_end) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_idx_q  <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      beat_total_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_total_q <= beat_total_d;
    end
  end

endmodule

// File: tb/tb_pp_stream_rr_arbiter.sv
// Bench for pp_stream_rr_arbiter. Two instances share clock, reset, enable
// and out_full_n: dut_a with BURST_LEN=16 and dut_b with BURST_LEN=1. The
// bench-side source queues feed whichever instance is selected. The other
// instance sees all requesters empty.

module tb_pp_stream_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic full_n;

  logic [NR-1:0]    a_empty_n, b_empty_n, a_read, b_read;
  logic [NR*DW-1:0] a_dout, b_dout;
  logic             a_write, b_write, a_busy, b_busy;
  logic [DW-1:0]    a_din, b_din;
  logic [SW-1:0]    a_src, b_src;
  logic [CW-1:0]    a_total, b_total;

  logic             sel_b;
  logic [NR-1:0]    obs_read;
  logic             obs_write, obs_busy;
  logic [DW-1:0]    obs_din;
  logic [SW-1:0]    obs_src;
  logic [CW-1:0]    obs_total;

  logic [DW-1:0]    src_q [NR][$];
  logic [SW+DW-1:0] exp_q[$];
  int               wr_log[$];
  int               src_log[$];
  int               busy_log[$];
  int               checks = 0;
  int               errors = 0;
  int               total_writes = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  pp_stream_rr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .BURST_LEN(16), .CNT_WIDTH(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .req_empty_n(a_empty_n), .req_dout(a_dout), .req_read(a_read),
    .out_full_n(full_n), .out_write(a_write), .out_din(a_din), .out_src(a_src),
    .busy(a_busy), .beat_total(a_total)
  );

  pp_stream_rr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .BURST_LEN(1), .CNT_WIDTH(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .req_empty_n(b_empty_n), .req_dout(b_dout), .req_read(b_read),
    .out_full_n(full_n), .out_write(b_write), .out_din(b_din), .out_src(b_src),
    .busy(b_busy), .beat_total(b_total)
  );

  always_comb begin
    obs_read  = sel_b ? b_read  : a_read;
    obs_write = sel_b ? b_write : a_write;
    obs_busy  = sel_b ? b_busy  : a_busy;
    obs_din   = sel_b ? b_din   : a_din;
    obs_src   = sel_b ? b_src   : a_src;
    obs_total = sel_b ? b_total : a_total;
  end

  // ---------------- driver tasks ----------------

  task automatic drive_sources();
    for (int i = 0; i < NR; i++) begin
      logic          ne;
      logic [DW-1:0] w;
      ne = (src_q[i].size() != 0);
      w  = ne ? src_q[i][0] : (32'hDEAD_0000 | 32'(i));
      a_empty_n[i] = ne && !sel_b;
      b_empty_n[i] = ne && sel_b;
      a_dout[i*DW +: DW] = w;
      b_dout[i*DW +: DW] = w;
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    src_log.delete();
    busy_log.delete();
  endtask

  task automatic fill(input int r, input int n);
    for (int k = 0; k < n; k++) src_q[r].push_back($urandom);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    full_n = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    drive_sources();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total_writes = 0;
    clear_logs();
  endtask

  // One clock: present sources, sample and score at negedge, pop on posedge.
  task automatic step_cycle();
    logic [NR-1:0]    rd;
    logic [SW+DW-1:0] got;
    logic [SW+DW-1:0] want;
    logic [DW-1:0]    junk;
    drive_sources();
    @(negedge clk);
    rd = obs_read;
    wr_log.push_back(int'(obs_write));
    src_log.push_back(int'(obs_src));
    busy_log.push_back(int'(obs_busy));
    checks++;
    if (obs_write !== (|obs_read) || !$onehot0(obs_read)) begin
      errors++;
      $display("FAIL strobe_shape: got write=%b read=%b expected write=OR(read), read one-hot or zero",
               obs_write, obs_read);
    end
    if (obs_write === 1'b1) begin
      checks++;
      if (full_n !== 1'b1 || rd[obs_src] !== 1'b1 || src_q[obs_src].size() == 0) begin
        errors++;
        $display("FAIL strobe_legal: got full_n=%b read=%b src=%0d qsize=%0d expected legal pop",
                 full_n, rd, obs_src, src_q[obs_src].size());
      end
      got = {obs_src, obs_din};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_order: got unexpected beat %0h expected none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL beat_order: got src/word %0h expected %0h", got, want);
        end
      end
      total_writes++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rd[i] === 1'b1 && src_q[i].size() != 0) junk = src_q[i].pop_front();
    end
  endtask

  // Reference model: burst-level round robin over the current queue contents.
  task automatic build_expected(input int burst, input int ptr0);
    int len [NR];
    int pos [NR];
    int ptr, remaining, pick, n;
    ptr = ptr0;
    remaining = 0;
    for (int i = 0; i < NR; i++) begin
      len[i] = src_q[i].size();
      pos[i] = 0;
      remaining += len[i];
    end
    while (remaining > 0) begin
      pick = -1;
      for (int k = NR - 1; k >= 0; k--) begin
        if (pos[(ptr + k) % NR] < len[(ptr + k) % NR]) pick = (ptr + k) % NR;
      end
      n = len[pick] - pos[pick];
      if (n > burst) n = burst;
      for (int k = 0; k < n; k++) exp_q.push_back({SW'(pick), src_q[pick][pos[pick] + k]});
      pos[pick] += n;
      remaining -= n;
      ptr = (pick + 1) % NR;
    end
  endtask

  task automatic run_until_drained(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step_cycle();
      n++;
    end
    repeat (3) step_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, exp_q.size());
    end
    checks++;
    if (obs_total !== CW'(total_writes)) begin
      errors++;
      $display("FAIL %s_total: got %0d expected %0d", name, obs_total, total_writes);
    end
    checks++;
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got busy=%b expected 0", name, obs_busy);
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    sel_b = 1'b0;
    do_reset();
    checks++;
    if ({a_read, a_write, a_src, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs: got read=%b write=%b src=%0d busy=%b expected zeros",
               a_read, a_write, a_src, a_busy);
    end
    checks++;
    if (a_total !== '0) begin
      errors++;
      $display("FAIL reset_a_total: got %0d expected 0", a_total);
    end
    checks++;
    if ({b_read, b_write, b_src, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_b_outputs: got read=%b write=%b src=%0d busy=%b expected zeros",
               b_read, b_write, b_src, b_busy);
    end
    checks++;
    if (b_total !== '0) begin
      errors++;
      $display("FAIL reset_b_total: got %0d expected 0", b_total);
    end
  endtask

  task automatic test_single_source();
    int bad;
    sel_b = 1'b0;
    do_reset();
    fill(2, 5);
    build_expected(16, 0);
    enable = 1'b1;
    run_until_drained("single", 40);
    bad = 0;
    if (wr_log[0] != 0 || busy_log[0] != 0) bad++;
    for (int c = 1; c <= 5; c++) if (wr_log[c] != 1 || src_log[c] != 2) bad++;
    if (wr_log[6] != 0 || busy_log[6] != 1 || busy_log[7] != 0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_timing: got %0d cycle mismatches expected 0 (idle, 5 beats src2, end on empty)", bad);
    end
    checks++;
    if (a_total !== 32'd5) begin
      errors++;
      $display("FAIL single_total: got %0d expected 5", a_total);
    end
  endtask

  task automatic test_two_sources();
    int rs[$];
    int rl[$];
    int want_s[4] = '{0, 1, 0, 1};
    int want_l[4] = '{16, 16, 4, 4};
    int ok;
    sel_b = 1'b0;
    do_reset();
    fill(0, 20);
    fill(1, 20);
    build_expected(16, 0);
    enable = 1'b1;
    run_until_drained("two_src", 200);
    for (int k = 0; k < wr_log.size(); k++) begin
      if (wr_log[k] == 1) begin
        if (rs.size() != 0 && rs[rs.size()-1] == src_log[k]) rl[rl.size()-1] = rl[rl.size()-1] + 1;
        else begin
          rs.push_back(src_log[k]);
          rl.push_back(1);
        end
      end
    end
    ok = (rs.size() == 4);
    if (ok) for (int j = 0; j < 4; j++) if (rs[j] != want_s[j] || rl[j] != want_l[j]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL two_src_runs: got %0d runs (first len %0d) expected 16 src0,16 src1,4 src0,4 src1",
               rs.size(), (rl.size() != 0) ? rl[0] : 0);
    end
    checks++;
    if (a_total !== 32'd40) begin
      errors++;
      $display("FAIL two_src_total: got %0d expected 40", a_total);
    end
  endtask

  task automatic test_strict_rr_bl1();
    int last, bad, nw;
    sel_b = 1'b1;
    do_reset();
    for (int r = 0; r < NR; r++) fill(r, 6);
    build_expected(1, 0);
    enable = 1'b1;
    run_until_drained("bl1", 200);
    last = -1;
    bad  = 0;
    nw   = 0;
    for (int k = 0; k < wr_log.size(); k++) begin
      if (wr_log[k] == 1) begin
        if (last >= 0 && k - last != 2) bad++;
        if (src_log[k] != nw % NR) bad++;
        last = k;
        nw++;
      end
    end
    checks++;
    if (bad != 0 || nw != 24) begin
      errors++;
      $display("FAIL bl1_rotation: got %0d beats, %0d spacing/order errors expected 24 beats, 0 errors", nw, bad);
    end
  endtask

  task automatic test_backpressure();
    int bad, nw;
    sel_b = 1'b0;
    do_reset();
    fill(0, 20);
    build_expected(16, 0);
    enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      full_n = (c >= 6 && c <= 8) ? 1'b0 : 1'b1;
      step_cycle();
    end
    full_n = 1'b1;
    run_until_drained("bp", 100);
    bad = 0;
    for (int c = 6; c <= 8; c++) if (wr_log[c] != 0 || busy_log[c] != 1 || src_log[c] != 0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stall: got %0d stall-cycle errors expected 0 (no strobes, grant kept)", bad);
    end
    nw = 0;
    for (int c = 1; c <= 19; c++) nw += wr_log[c];
    checks++;
    if (nw != 16 || busy_log[20] != 0 || wr_log[20] != 0) begin
      errors++;
      $display("FAIL bp_burst_len: got %0d beats, busy@20=%0d expected 16 beats then idle", nw, busy_log[20]);
    end
  endtask

  task automatic test_enable_drop();
    int bad, want_next;
    for (int v = 0; v < 2; v++) begin
      sel_b = 1'b0;
      do_reset();
      fill(1, 20);
      if (v == 0) fill(2, 5);
      fill(3, 3);
      want_next = (v == 0) ? 2 : 3;
      for (int k = 0; k < 7; k++) exp_q.push_back({2'd1, src_q[1][k]});
      for (int c = 0; c < 12; c++) begin
        enable = (c >= 8) ? 1'b0 : 1'b1;
        step_cycle();
      end
      enable = 1'b1;
      build_expected(16, 2);
      run_until_drained("enable", 200);
      bad = 0;
      for (int c = 8; c <= 12; c++) if (wr_log[c] != 0) bad++;
      if (busy_log[8] != 1) bad++;
      for (int c = 9; c <= 12; c++) if (busy_log[c] != 0) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL enable_pause_v%0d: got %0d errors expected 0 (no strobes while disabled)", v, bad);
      end
      checks++;
      if (wr_log[13] != 1 || src_log[13] != want_next) begin
        errors++;
        $display("FAIL enable_resume_v%0d: got write=%0d src=%0d expected write=1 src=%0d",
                 v, wr_log[13], src_log[13], want_next);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int first_src;
    sel_b = 1'b0;
    do_reset();
    fill(3, 20);
    for (int k = 0; k < 5; k++) exp_q.push_back({2'd3, src_q[3][k]});
    enable = 1'b1;
    for (int c = 0; c < 6; c++) step_cycle();
    reset = 1'b1;
    step_cycle();
    checks++;
    if (wr_log[6] != 0) begin
      errors++;
      $display("FAIL rst_mid_strobe: got write=%0d expected 0", wr_log[6]);
    end
    checks++;
    if (a_read !== '0 || a_write !== 1'b0 || a_busy !== 1'b0 || a_total !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: got read=%b write=%b busy=%b total=%0d expected zeros",
               a_read, a_write, a_busy, a_total);
    end
    reset = 1'b0;
    total_writes = 0;
    clear_logs();
    fill(0, 4);
    fill(1, 4);
    build_expected(16, 0);
    run_until_drained("rst_mid", 200);
    first_src = -1;
    for (int k = wr_log.size() - 1; k >= 0; k--) if (wr_log[k] == 1) first_src = src_log[k];
    checks++;
    if (first_src != 0 || a_total !== 32'd23) begin
      errors++;
      $display("FAIL rst_mid_regrant: got first src %0d total %0d expected src 0 total 23", first_src, a_total);
    end
  endtask

  task automatic test_random();
    int n;
    for (int round = 0; round < 6; round++) begin
      sel_b = ($urandom_range(0, 1) == 1);
      do_reset();
      for (int r = 0; r < NR; r++) fill(r, $urandom_range(0, 24));
      build_expected(sel_b ? 1 : 16, 0);
      enable = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
        full_n = ($urandom_range(0, 3) != 0);
        step_cycle();
        n++;
      end
      full_n = 1'b1;
      run_until_drained("random", 100);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    full_n = 1'b1;
    sel_b = 1'b0;
    test_reset();
    test_single_source();
    test_two_sources();
    test_strict_rr_bl1();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
